// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
//   Bulk-load engine placed in front of ram_4k. Accepts a byte stream over a
//   valid/ready handshake, packs byte pairs into 16-bit words (high byte
//   first) and writes them to consecutive RAM addresses starting at a
//   programmable base. Used to preload data memory before the CPU is
//   released from reset.
//
// Ports
//   clock       in   system clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset, highest priority
//   start       in   begin a load (only looked at while idle)
//   base_addr   in   first RAM address written, latched with start
//   word_count  in   number of words to write, latched with start
//   byte_in     in   stream data
//   byte_valid  in   byte_in holds a valid byte
//   byte_ready  out  loader accepts a byte this cycle
//   ram_in      out  write data to ram_4k
//   ram_addr    out  address to ram_4k
//   ram_load    out  write enable to ram_4k (one cycle per word)
//   busy        out  load in progress
//   done        out  one-cycle pulse at the end of a load
//
// Every output is a flop; nothing combinational reaches an output port.
// ---------------------------------------------------------------------------
module ram_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 13
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [15:0]            ram_in,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_load,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [7:0]             high_byte_q;
  logic                   byte_ready_q;
  logic [15:0]            ram_in_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic                   ram_load_q;
  logic                   busy_q;
  logic                   done_q;

  // byte_ready_q is only set in HIGH/LOW, so this is the handshake itself.
  logic byte_accept;
  assign byte_accept = byte_valid & byte_ready_q;

  // Outputs are declared one cycle ahead: each transition loads the output
  // flops with the values belonging to the state being entered.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      high_byte_q  <= '0;
      byte_ready_q <= 1'b0;
      ram_in_q     <= '0;
      ram_addr_q   <= '0;
      ram_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Single-cycle strobes; re-asserted only by the transitions below.
      ram_load_q <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
            busy_q      <= 1'b1;
            if (word_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_HIGH;
              byte_ready_q <= 1'b1;
            end
          end
        end

        S_HIGH: begin
          if (byte_accept) begin
            high_byte_q <= byte_in;
            state_q     <= S_LOW;
          end
        end

        S_LOW: begin
          if (byte_accept) begin
            ram_in_q     <= {high_byte_q, byte_in};
            ram_addr_q   <= addr_q;
            ram_load_q   <= 1'b1;
            byte_ready_q <= 1'b0;
            state_q      <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The address counter wraps naturally at 2^ADDR_WIDTH.
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          remaining_q <= remaining_q - COUNT_WIDTH'(1);
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= S_HIGH;
            byte_ready_q <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign ram_in     = ram_in_q;
  assign ram_addr   = ram_addr_q;
  assign ram_load   = ram_load_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
//   Directed bench for ram_loader. A behavioural 4K x 16 RAM captures every
//   ram_load strobe so writes can be read back; a write log records address,
//   data and the capturing edge for ordering and latency checks.
// ---------------------------------------------------------------------------
module tb_ram_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ram_in;
  logic [11:0] ram_addr;
  logic        ram_load;
  logic        busy;
  logic        done;

  ram_loader #(
    .ADDR_WIDTH (12),
    .COUNT_WIDTH(13)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_load  (ram_load),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic [15:0] mem [0:4095];
  wr_t         wlog [$];
  int          cyc;
  int          done_cnt;
  int          acc_cnt;
  int          n_tests;
  int          n_fail;
  int          start_cyc;

  // Edge-accurate observer: RAM write, done pulses and handshakes as seen at
  // the rising edge (pre-update values).
  always @(posedge clock) begin
    wr_t w;
    cyc++;
    if (ram_load) begin
      mem[ram_addr] = ram_in;
      w.addr = ram_addr;
      w.data = ram_in;
      w.cyc  = cyc;
      wlog.push_back(w);
    end
    if (done) done_cnt++;
    if (byte_valid && byte_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [11:0] base, input logic [12:0] count);
    base_addr  = base;
    word_count = count;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    start_cyc  = cyc;
  endtask

  // Present one byte after `gap` idle cycles and hold it until consumed.
  task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  // Wait (bounded) until done is seen, then confirm it is a single pulse.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [11:0] addr, input logic [15:0] data);
    if (idx < wlog.size()) begin
      check({tag, "_addr"}, 32'(wlog[idx].addr), 32'(addr));
      check({tag, "_data"}, 32'(wlog[idx].data), 32'(data));
    end else begin
      check({tag, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    cyc        = 0;
    done_cnt   = 0;
    acc_cnt    = 0;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // ---- reset state
    tick();
    tick();
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_ram_in",     32'(ram_in),     32'd0);
    check("rst_ram_addr",   32'(ram_addr),   32'd0);
    check("rst_ram_load",   32'(ram_load),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    reset = 1'b0;
    tick();

    // ---- basic load: 0x1234 @0x010, 0xABCD @0x011
    wlog.delete();
    d0 = done_cnt;
    do_start(12'h010, 13'd2);
    check("basic_busy",  32'(busy),       32'd1);
    check("basic_ready", 32'(byte_ready), 32'd1);
    send_byte("basic_b0", 8'h12, 0);
    send_byte("basic_b1", 8'h34, 0);
    send_byte("basic_b2", 8'hAB, 0);
    send_byte("basic_b3", 8'hCD, 0);
    wait_done("basic");
    check("basic_nwrites", 32'(wlog.size()), 32'd2);
    check_write("basic_w0", 0, 12'h010, 16'h1234);
    check_write("basic_w1", 1, 12'h011, 16'hABCD);
    if (wlog.size() > 0) check("basic_latency", 32'(wlog[0].cyc - start_cyc), 32'd3);
    check("basic_ndone", 32'(done_cnt - d0), 32'd1);
    check("basic_rd010", 32'(mem[12'h010]), 32'h1234);
    check("basic_rd011", 32'(mem[12'h011]), 32'hABCD);

    // ---- address wrap: 0xFFF then 0x000
    wlog.delete();
    do_start(12'hFFF, 13'd2);
    send_byte("wrap_b0", 8'h00, 0);
    send_byte("wrap_b1", 8'h01, 0);
    send_byte("wrap_b2", 8'h00, 0);
    send_byte("wrap_b3", 8'h02, 0);
    wait_done("wrap");
    check("wrap_nwrites", 32'(wlog.size()), 32'd2);
    check_write("wrap_w0", 0, 12'hFFF, 16'h0001);
    check_write("wrap_w1", 1, 12'h000, 16'h0002);
    check("wrap_rdFFF", 32'(mem[12'hFFF]), 32'h0001);
    check("wrap_rd000", 32'(mem[12'h000]), 32'h0002);

    // ---- zero count: straight to DONE, no writes, never ready
    wlog.delete();
    d0 = done_cnt;
    do_start(12'h200, 13'd0);
    check("zero_done_hi",  32'(done),       32'd1);
    check("zero_busy_hi",  32'(busy),       32'd1);
    check("zero_ready_c1", 32'(byte_ready), 32'd0);
    tick();
    check("zero_done_lo",  32'(done),       32'd0);
    check("zero_busy_lo",  32'(busy),       32'd0);
    check("zero_ready_c2", 32'(byte_ready), 32'd0);
    repeat (3) tick();
    check("zero_nwrites", 32'(wlog.size()), 32'd0);
    check("zero_ndone",   32'(done_cnt - d0), 32'd1);

    // ---- backpressure: bytes separated by 2-cycle gaps
    wlog.delete();
    a0 = acc_cnt;
    do_start(12'h100, 13'd1);
    send_byte("bp_b0", 8'hBE, 2);
    check("bp_no_early_write", 32'(wlog.size()), 32'd0);
    send_byte("bp_b1", 8'hEF, 2);
    wait_done("bp");
    check("bp_nwrites", 32'(wlog.size()), 32'd1);
    check_write("bp_w0", 0, 12'h100, 16'hBEEF);
    check("bp_accepted", 32'(acc_cnt - a0), 32'd2);
    check("bp_rd100", 32'(mem[12'h100]), 32'hBEEF);

    // ---- reset mid-load: high byte taken, then reset
    wlog.delete();
    do_start(12'h020, 13'd4);
    send_byte("rml_b0", 8'h77, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rml_byte_ready", 32'(byte_ready), 32'd0);
    check("rml_ram_in",     32'(ram_in),     32'd0);
    check("rml_ram_addr",   32'(ram_addr),   32'd0);
    check("rml_ram_load",   32'(ram_load),   32'd0);
    check("rml_busy",       32'(busy),       32'd0);
    check("rml_done",       32'(done),       32'd0);
    repeat (4) tick();
    check("rml_nwrites", 32'(wlog.size()), 32'd0);
    do_start(12'h020, 13'd1);
    send_byte("rml_b1", 8'h5A, 0);
    send_byte("rml_b2", 8'h5A, 0);
    wait_done("rml");
    check("rml_nwrites2", 32'(wlog.size()), 32'd1);
    check_write("rml_w0", 0, 12'h020, 16'h5A5A);
    check("rml_rd020", 32'(mem[12'h020]), 32'h5A5A);

    // ---- start pulsed while busy must be ignored
    wlog.delete();
    d0 = done_cnt;
    do_start(12'h040, 13'd2);
    send_byte("sdb_b0", 8'h11, 0);
    base_addr  = 12'h300;
    word_count = 13'd5;
    start      = 1'b1;
    send_byte("sdb_b1", 8'h22, 0);
    start      = 1'b0;
    send_byte("sdb_b2", 8'h33, 0);
    send_byte("sdb_b3", 8'h44, 0);
    wait_done("sdb");
    repeat (5) tick();
    check("sdb_nwrites", 32'(wlog.size()), 32'd2);
    check_write("sdb_w0", 0, 12'h040, 16'h1122);
    check_write("sdb_w1", 1, 12'h041, 16'h3344);
    check("sdb_ndone", 32'(done_cnt - d0), 32'd1);
    check("sdb_idle_busy", 32'(busy), 32'd0);
    check("sdb_rd300", 32'(mem[12'h300]), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
